// File: rtl/pipe_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_pkg : shared types and constants for the pipeline hazard unit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALT   = 2'd1,
    RESUME = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// ----------------------------------------------------------------------------
// fwd_sel : combinational forward-select for one ID-stage source register
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fwd_sel
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] i_src,
  input  logic       i_used,
  input  logic       i_ex_effective,
  input  logic       i_ex_regwrite,
  input  logic       i_ex_memtoreg,
  input  logic [4:0] i_ex_rd,
  input  logic       i_mem_regwrite,
  input  logic [4:0] i_mem_rd,
  output logic [1:0] o_sel
);

  logic w_ex_hit;
  logic w_mem_hit;

  // A load in EX has no result yet; the load-use stall covers that case.
  assign w_ex_hit  = i_ex_effective & i_ex_regwrite & ~i_ex_memtoreg &
                     (i_ex_rd != 5'd0) & i_used & (i_src == i_ex_rd);
  assign w_mem_hit = i_mem_regwrite & (i_mem_rd != 5'd0) & i_used &
                     (i_src == i_mem_rd);

  always_comb begin
    o_sel = FWD_RF;
    if (w_ex_hit)
      o_sel = FWD_EX;
    else if (w_mem_hit)
      o_sel = FWD_MEM;
  end

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl : load-use stalls, branch squashes, syscall halt FSM and
// operand forwarding. Optional PIPE_HAZARD_STATS_EN adds event counters.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ex_effective,
  input  logic       ex_memtoreg,
  input  logic       ex_regwrite,
  input  logic [4:0] ex_rd,
  input  logic       ex_beq,
  input  logic       ex_bne,
  input  logic       ex_jmp,
  input  logic       ex_jr,
  input  logic       ex_equal,
  input  logic       ex_syscall,
  input  logic       ex_halt_req,
  input  logic       mem_regwrite,
  input  logic [4:0] mem_rd,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic       resume,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       id_ex_stall,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       redirect,
  output logic       halted,
  output logic [1:0] r1_forward,
  output logic [1:0] r2_forward
`ifdef PIPE_HAZARD_STATS_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  state_t r_state;
  logic   w_taken;
  logic   w_load_use;
  logic   w_halt_hit;

  assign w_taken = ex_effective & (ex_jmp | ex_jr | (ex_beq & ex_equal) |
                                   (ex_bne & ~ex_equal));

  assign w_load_use = ex_effective & ex_memtoreg & ex_regwrite & (ex_rd != 5'd0) &
                      ((id_rs_used & (id_rs == ex_rd)) |
                       (id_rt_used & (id_rt == ex_rd)));

  // Only RUN honours the halt request, so the syscall retires from RESUME.
  assign w_halt_hit = (r_state == RUN) & ex_effective & ex_syscall & ex_halt_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      case (r_state)
        RUN:     if (w_halt_hit) r_state <= HALT;
        HALT:    if (resume) r_state <= RESUME;
        RESUME:  r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

  always_comb begin
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    id_ex_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    redirect    = 1'b0;
    if (r_state == HALT || w_halt_hit) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_stall = 1'b1;
    end else if (w_taken) begin
      redirect    = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (w_load_use) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  assign halted = (r_state == HALT);

  fwd_sel u_fwd_rs (
    .i_src          (id_rs),
    .i_used         (id_rs_used),
    .i_ex_effective (ex_effective),
    .i_ex_regwrite  (ex_regwrite),
    .i_ex_memtoreg  (ex_memtoreg),
    .i_ex_rd        (ex_rd),
    .i_mem_regwrite (mem_regwrite),
    .i_mem_rd       (mem_rd),
    .o_sel          (r1_forward)
  );

  fwd_sel u_fwd_rt (
    .i_src          (id_rt),
    .i_used         (id_rt_used),
    .i_ex_effective (ex_effective),
    .i_ex_regwrite  (ex_regwrite),
    .i_ex_memtoreg  (ex_memtoreg),
    .i_ex_rd        (ex_rd),
    .i_mem_regwrite (mem_regwrite),
    .i_mem_rd       (mem_rd),
    .o_sel          (r2_forward)
  );

`ifdef PIPE_HAZARD_STATS_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;
  logic        w_bubble;

  // A bubble is the flush-without-redirect pattern of the load-use path.
  assign w_bubble = id_ex_flush & ~redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt <= 32'd0;
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (r_state != HALT) r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (w_bubble)        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (redirect)        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign cycle_cnt = r_cycle_cnt;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl : scoreboard bench for pipe_hazard_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       eff, mtr, rw;
    logic [4:0] rd;
    logic       beq, bne, jmp, jr, eq, sys, hreq, mrw;
    logic [4:0] mrd, rs, rt;
    logic       rsu, rtu, res;
  } stim_t;

  // {pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, redirect,
  //  halted, r1_forward[1:0], r2_forward[1:0]}
  localparam logic [10:0] O_NONE = 11'b000_000_0_00_00;
  localparam logic [10:0] O_LU   = 11'b110_010_0_00_00;
  localparam logic [10:0] O_BR   = 11'b000_111_0_00_00;
  localparam logic [10:0] O_HS   = 11'b111_000_0_00_00;
  localparam logic [10:0] O_HALT = 11'b111_000_1_00_00;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ex_effective, ex_memtoreg, ex_regwrite;
  logic [4:0] ex_rd;
  logic       ex_beq, ex_bne, ex_jmp, ex_jr, ex_equal, ex_syscall, ex_halt_req;
  logic       mem_regwrite;
  logic [4:0] mem_rd, id_rs, id_rt;
  logic       id_rs_used, id_rt_used, resume;
  logic       pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush;
  logic       redirect, halted;
  logic [1:0] r1_forward, r2_forward;
`ifdef PIPE_HAZARD_STATS_EN
  logic [31:0] cycle_cnt, stall_cnt, flush_cnt;
`endif

  int n_vec  = 0;
  int n_miss = 0;
  logic [10:0] exp_q[$];
  logic [31:0] m_cyc = 0, m_stall = 0, m_flush = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_effective (ex_effective),
    .ex_memtoreg  (ex_memtoreg),
    .ex_regwrite  (ex_regwrite),
    .ex_rd        (ex_rd),
    .ex_beq       (ex_beq),
    .ex_bne       (ex_bne),
    .ex_jmp       (ex_jmp),
    .ex_jr        (ex_jr),
    .ex_equal     (ex_equal),
    .ex_syscall   (ex_syscall),
    .ex_halt_req  (ex_halt_req),
    .mem_regwrite (mem_regwrite),
    .mem_rd       (mem_rd),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rs_used   (id_rs_used),
    .id_rt_used   (id_rt_used),
    .resume       (resume),
    .pc_stall     (pc_stall),
    .if_id_stall  (if_id_stall),
    .id_ex_stall  (id_ex_stall),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .redirect     (redirect),
    .halted       (halted),
    .r1_forward   (r1_forward),
    .r2_forward   (r2_forward)
`ifdef PIPE_HAZARD_STATS_EN
    ,
    .cycle_cnt    (cycle_cnt),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  function automatic logic [10:0] obs();
    return {pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush,
            redirect, halted, r1_forward, r2_forward};
  endfunction

  task automatic drive(input stim_t s);
    ex_effective = s.eff;  ex_memtoreg = s.mtr;  ex_regwrite = s.rw;
    ex_rd        = s.rd;   ex_beq      = s.beq;  ex_bne      = s.bne;
    ex_jmp       = s.jmp;  ex_jr       = s.jr;   ex_equal    = s.eq;
    ex_syscall   = s.sys;  ex_halt_req = s.hreq; mem_regwrite = s.mrw;
    mem_rd       = s.mrd;  id_rs       = s.rs;   id_rt       = s.rt;
    id_rs_used   = s.rsu;  id_rt_used  = s.rtu;  resume      = s.res;
  endtask

  // Advance past the next edge, updating the counter model from the
  // expected control vector of the cycle just checked.
  task automatic tick(input logic [10:0] e);
    @(posedge clk);
    if (rst_n) begin
      if (!e[4])         m_cyc   = m_cyc + 1;
      if (e[6] && !e[5]) m_stall = m_stall + 1;
      if (e[5])          m_flush = m_flush + 1;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [10:0] e, g;
    rst_n = 1'b0;
    drive('0);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(O_NONE);
      @(negedge clk);
      g = obs(); e = exp_q.pop_front(); n_vec++;
      if (g !== e) begin
        n_miss++;
        $display("FAIL reset[%0d]: got %b want %b", i, g, e);
      end
      tick(e);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    stim_t s[5]; logic [10:0] x[5]; logic [10:0] e, g;
    s[0] = stim_t'{eff:1'b1, mtr:1'b1, rw:1'b1, rd:5'd8, rs:5'd8, rsu:1'b1, default:'0};
    x[0] = O_LU;
    s[1] = stim_t'{mrw:1'b1, mrd:5'd8, rs:5'd8, rsu:1'b1, default:'0};
    x[1] = 11'b000_000_0_10_00;
    s[2] = stim_t'{eff:1'b1, mtr:1'b1, rw:1'b1, rd:5'd5, rt:5'd5, rtu:1'b1, default:'0};
    x[2] = O_LU;
    s[3] = stim_t'{eff:1'b1, mtr:1'b1, rw:1'b1, rd:5'd0, rs:5'd0, rsu:1'b1, default:'0};
    x[3] = O_NONE;
    s[4] = stim_t'{eff:1'b1, mtr:1'b1, rw:1'b1, rd:5'd7, rs:5'd7, rsu:1'b0, default:'0};
    x[4] = O_NONE;
    for (int i = 0; i < 5; i++) begin
      drive(s[i]);
      exp_q.push_back(x[i]);
      @(negedge clk);
      g = obs(); e = exp_q.pop_front(); n_vec++;
      if (g !== e) begin
        n_miss++;
        $display("FAIL load_use[%0d]: got %b want %b", i, g, e);
      end
`ifdef PIPE_HAZARD_STATS_EN
      if (i == 1) begin
        n_vec++;
        if (stall_cnt !== m_stall) begin
          n_miss++;
          $display("FAIL load_use_stall_cnt: got %0d want %0d", stall_cnt, m_stall);
        end
      end
`endif
      tick(e);
    end
  endtask

  task automatic test_branch();
    stim_t s[5]; logic [10:0] x[5]; logic [10:0] e, g;
    s[0] = stim_t'{eff:1'b1, beq:1'b1, eq:1'b1, default:'0}; x[0] = O_BR;
    s[1] = stim_t'{eff:1'b1, beq:1'b1, eq:1'b0, default:'0}; x[1] = O_NONE;
    s[2] = stim_t'{eff:1'b1, bne:1'b1, eq:1'b0, default:'0}; x[2] = O_BR;
    s[3] = stim_t'{eff:1'b1, jmp:1'b1, default:'0};          x[3] = O_BR;
    s[4] = stim_t'{eff:1'b0, jr:1'b1, default:'0};           x[4] = O_NONE;
    for (int i = 0; i < 5; i++) begin
      drive(s[i]);
      exp_q.push_back(x[i]);
      @(negedge clk);
      g = obs(); e = exp_q.pop_front(); n_vec++;
      if (g !== e) begin
        n_miss++;
        $display("FAIL branch[%0d]: got %b want %b", i, g, e);
      end
      tick(e);
    end
  endtask

  task automatic test_forward();
    stim_t s[5]; logic [10:0] x[5]; logic [10:0] e, g;
    s[0] = stim_t'{eff:1'b1, rw:1'b1, rd:5'd9, mrw:1'b1, mrd:5'd9, rt:5'd9, rtu:1'b1, default:'0};
    x[0] = 11'b000_000_0_00_01;
    s[1] = stim_t'{eff:1'b1, rw:1'b1, rd:5'd0, mrw:1'b1, mrd:5'd9, rt:5'd9, rtu:1'b1, default:'0};
    x[1] = 11'b000_000_0_00_10;
    s[2] = stim_t'{eff:1'b1, rw:1'b1, rd:5'd0, mrw:1'b1, mrd:5'd9, rt:5'd0, rtu:1'b1, default:'0};
    x[2] = O_NONE;
    s[3] = stim_t'{eff:1'b1, rw:1'b1, rd:5'd9, mrw:1'b1, mrd:5'd3, rs:5'd9, rt:5'd3,
                   rsu:1'b1, rtu:1'b1, default:'0};
    x[3] = 11'b000_000_0_01_10;
    s[4] = stim_t'{eff:1'b0, rw:1'b1, rd:5'd4, mrw:1'b1, mrd:5'd0, rs:5'd4, rt:5'd0,
                   rsu:1'b1, rtu:1'b1, default:'0};
    x[4] = O_NONE;
    for (int i = 0; i < 5; i++) begin
      drive(s[i]);
      exp_q.push_back(x[i]);
      @(negedge clk);
      g = obs(); e = exp_q.pop_front(); n_vec++;
      if (g !== e) begin
        n_miss++;
        $display("FAIL forward[%0d]: got %b want %b", i, g, e);
      end
      tick(e);
    end
  endtask

  task automatic test_halt_resume();
    stim_t s[11]; logic [10:0] x[11]; logic [10:0] e, g;
    stim_t sc;
    sc = stim_t'{eff:1'b1, sys:1'b1, hreq:1'b1, default:'0};
    s[0] = sc; x[0] = O_HS;
    s[1] = sc; x[1] = O_HALT;
    s[2] = sc; s[2].jmp = 1'b1; x[2] = O_HALT;
    s[3] = sc; s[3].res = 1'b1; x[3] = O_HALT;
    s[4] = sc; x[4] = O_NONE;   // RESUME masks the still-present syscall
    s[5] = sc; x[5] = O_HS;     // back in RUN, so it halts again
    s[6] = sc; s[6].res = 1'b1; x[6] = O_HALT;
    s[7] = sc; s[7].jmp = 1'b1; x[7] = O_BR;
    s[8] = '0; x[8] = O_NONE;
    s[9] = '0; s[9].res = 1'b1; x[9] = O_NONE;
    s[10] = '0; x[10] = O_NONE;
    for (int i = 0; i < 11; i++) begin
      drive(s[i]);
      exp_q.push_back(x[i]);
      @(negedge clk);
      g = obs(); e = exp_q.pop_front(); n_vec++;
      if (g !== e) begin
        n_miss++;
        $display("FAIL halt_resume[%0d]: got %b want %b", i, g, e);
      end
      tick(e);
    end
  endtask

  task automatic test_simultaneous();
    stim_t s[5]; logic [10:0] x[5]; logic [10:0] e, g;
    s[0] = stim_t'{eff:1'b1, mtr:1'b1, rw:1'b1, rd:5'd8, rs:5'd8, rsu:1'b1, jmp:1'b1, default:'0};
    x[0] = O_BR;
    s[1] = stim_t'{eff:1'b1, sys:1'b1, hreq:1'b1, jmp:1'b1, default:'0};
    x[1] = O_HS;
    s[2] = s[1]; x[2] = O_HALT;
    s[3] = s[1]; s[3].res = 1'b1; x[3] = O_HALT;
    s[4] = '0;   x[4] = O_NONE;
    for (int i = 0; i < 5; i++) begin
      drive(s[i]);
      exp_q.push_back(x[i]);
      @(negedge clk);
      g = obs(); e = exp_q.pop_front(); n_vec++;
      if (g !== e) begin
        n_miss++;
        $display("FAIL simultaneous[%0d]: got %b want %b", i, g, e);
      end
      tick(e);
    end
  endtask

  task automatic test_reset_in_halt();
    stim_t s[4]; logic [10:0] x[4]; logic [10:0] e, g;
    drive(stim_t'{eff:1'b1, sys:1'b1, hreq:1'b1, default:'0});
    tick(O_HS);
    drive('0);
    tick(O_HALT);
    // Mid-cycle reset while halted: must clear without waiting for an edge.
    rst_n = 1'b0;
    m_cyc = 0; m_stall = 0; m_flush = 0;
    exp_q.push_back(O_NONE);
    #1;
    g = obs(); e = exp_q.pop_front(); n_vec++;
    if (g !== e) begin
      n_miss++;
      $display("FAIL async_reset_halt: got %b want %b", g, e);
    end
    @(negedge clk);
    tick(O_NONE);
    rst_n = 1'b1;
    s[0] = '0; s[0].res = 1'b1; x[0] = O_NONE;
    s[1] = '0; x[1] = O_NONE;
    s[2] = stim_t'{eff:1'b1, sys:1'b1, hreq:1'b1, default:'0}; x[2] = O_HS;
    s[3] = s[2]; s[3].res = 1'b1; x[3] = O_HALT;
    for (int i = 0; i < 4; i++) begin
      drive(s[i]);
      exp_q.push_back(x[i]);
      @(negedge clk);
      g = obs(); e = exp_q.pop_front(); n_vec++;
      if (g !== e) begin
        n_miss++;
        $display("FAIL reset_then_run[%0d]: got %b want %b", i, g, e);
      end
      tick(e);
    end
    drive('0);
    tick(O_NONE);
  endtask

  task automatic test_stats();
`ifdef PIPE_HAZARD_STATS_EN
    @(negedge clk);
    n_vec++;
    if (cycle_cnt !== m_cyc) begin
      n_miss++;
      $display("FAIL cycle_cnt: got %0d want %0d", cycle_cnt, m_cyc);
    end
    n_vec++;
    if (stall_cnt !== m_stall) begin
      n_miss++;
      $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, m_stall);
    end
    n_vec++;
    if (flush_cnt !== m_flush) begin
      n_miss++;
      $display("FAIL flush_cnt: got %0d want %0d", flush_cnt, m_flush);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_forward();
    test_halt_resume();
    test_simultaneous();
    test_stats();
    test_reset_in_halt();
    test_stats();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard and control unit for the 5-stage MIPS core. It consumes the instruction fields leaving the ID/EX register and the ID-stage source registers. It produces the hold, clear and redirect controls that drive the IF/ID and ID/EX registers and the PC, plus the R1/R2 forward selects latched into ID/EX. It owns load-use stalls, taken-branch/jump squashes, and the syscall halt/resume state machine.

## Interface
- No parameters.
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- ex_effective  in  1  ID/EX holds a valid instruction
- ex_memtoreg, ex_regwrite  in  1 each  EX-stage load / register-write flags
- ex_rd  in  5  EX-stage destination register
- ex_beq, ex_bne, ex_jmp, ex_jr  in  1 each  EX-stage control-transfer flags
- ex_equal  in  1  ALU equality flag for the EX instruction
- ex_syscall  in  1  EX-stage syscall
- ex_halt_req  in  1  syscall argument requests halt ($v0 == 10)
- mem_regwrite  in  1  MEM-stage register write
- mem_rd  in  5  MEM-stage destination register
- id_rs, id_rt  in  5 each  ID-stage source registers
- id_rs_used, id_rt_used  in  1 each  source register is actually read
- resume  in  1  single-cycle pulse that releases a halt
- pc_stall, if_id_stall, id_ex_stall  out  1 each  hold registers (1 = hold, matching the pipeline-register Enable)
- if_id_flush, id_ex_flush  out  1 each  clear registers on the next edge (synchronous clear input of the pipeline registers)
- redirect  out  1  PC takes the EX branch/jump target
- halted  out  1  core is halted
- r1_forward, r2_forward  out  2 each  forward select: 0 = register file, 1 = EX result, 2 = MEM result

## Operation
- Definitions:
  - taken = ex_effective & (ex_jmp | ex_jr | (ex_beq & ex_equal) | (ex_bne & ~ex_equal)).
  - load_use = ex_effective & ex_memtoreg & ex_regwrite & ex_rd≠0 & ((id_rs_used & id_rs==ex_rd) | (id_rt_used & id_rt==ex_rd)).
  - halt_hit = ex_effective & ex_syscall & ex_halt_req.
- FSM states: RUN, HALT, RESUME.
- RUN:
  - If halt_hit: go to HALT. In the same cycle assert pc/if_id/id_ex stall, so the syscall stays in EX.
  - Else if taken: assert redirect, if_id_flush and id_ex_flush, with all stalls 0.
  - Else if load_use: assert pc_stall, if_id_stall and id_ex_flush to insert one bubble.
  - Else: all outputs 0.
- HALT:
  - halted=1, and all three stalls are 1; flushes and redirect are 0.
  - resume=1 moves the FSM to RESUME.
- RESUME:
  - All stalls are 0 and halt_hit is masked, so the syscall retires.
  - taken and load_use are evaluated as in RUN.
  - Next state is RUN unconditionally.
- Priority: halt_hit > taken > load_use. A load_use that coincides with taken is squashed by the flush; no stall is issued.
- Forwarding, evaluated per source:
  - Select 1 if ex_effective & ex_regwrite & ~ex_memtoreg & ex_rd≠0 & match.
  - Otherwise select 2 if mem_regwrite & mem_rd≠0 & match.
  - Otherwise select 0.
  - The EX match wins over the MEM match. Register 0 never forwards.

## Timing
- Control outputs are combinational from the FSM state and the current inputs. They are sampled by the pipeline registers on the same rising edge, so there are 0 cycles of latency.
- A load-use stall lasts exactly 1 cycle: after the edge the load sits in MEM, and forwarding selects 2.
- Halt entry: halted rises the cycle after halt_hit is seen.
- Halt exit: resume at cycle N makes halted 0 at N+1 (RESUME), and the state is RUN at N+2.
- resume while in RUN or RESUME is ignored.
- Reset value of all outputs:
  - stalls, flushes, redirect, halted = 0; forward selects = 0.
  - FSM = RUN; counters = 0.
- Asynchronous reset during HALT returns the FSM to RUN immediately.

## Configuration
- PIPE_HAZARD_STATS_EN defined adds three 32-bit outputs:
  - cycle_cnt counts every cycle not in HALT.
  - stall_cnt counts load-use bubbles.
  - flush_cnt counts taken redirects.
  - All three counters wrap modulo 2^32 and reset to 0.
- PIPE_HAZARD_STATS_EN undefined: the ports and counters are absent; control behaviour is identical.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - the state enum (RUN/HALT/RESUME);
  - the forward-select constants FWD_RF=0, FWD_EX=1, FWD_MEM=2.
- Sub-module fwd_sel is instantiated twice, once per source. It is purely combinational (src, used, EX fields, MEM fields → 2-bit select).

## Test plan
- Load-use: lw $t0 in EX (ex_rd=8, memtoreg=1), ID reads id_rs=8 used → pc_stall=if_id_stall=id_ex_flush=1 for one cycle. Next cycle r1_forward=2 and stall_cnt=1.
- Branch: ex_beq=1, ex_equal=1, ex_effective=1 → redirect=if_id_flush=id_ex_flush=1 with stalls 0. Repeat with ex_equal=0 → all 0.
- Forward priority: ex_rd=mem_rd=9, both writing, id_rt=9 used → r2_forward=1. Set ex_rd=0 → r2_forward=2 (mem_rd=9 still matches). Set id_rt=0 → r2_forward=0.
- Halt/resume:
  - halt_hit at cycle 10 → halted=1 from cycle 11 with all stalls held.
  - resume pulse at cycle 20 → halted=0 at cycle 21 with no re-halt, although the syscall is still in EX; RUN at cycle 22.
- Simultaneous events: halt_hit with taken → HALT entered and no redirect. taken with load_use → flush only, stall_cnt unchanged.
- Reset: deassert rst_n while in HALT → halted=0 and outputs 0 asynchronously. After release, resume is ignored.
